// File: rtl/sd_cmd_host_arbiter.sv
// rtl/sd_cmd_host_arbiter.sv - round-robin sharing of the SD command serial host between two requesters.
// Optional host timeout / go-idle recovery is built when SD_CMD_TIMEOUT_EN is defined.
module sd_cmd_host_arbiter #(
   parameter int TIMEOUT_CYC = 1024,
   parameter int TO_W        = 11
) (
   input  logic        SD_CLK_IN,
   input  logic        RST_IN,
   input  logic        a_req_i,
   input  logic [39:0] a_cmd_i,
   input  logic [15:0] a_set_i,
   output logic        a_done_o,
   input  logic        b_req_i,
   input  logic [39:0] b_cmd_i,
   input  logic [15:0] b_set_i,
   output logic        b_done_o,
   output logic [39:0] rsp_o,
   output logic [7:0]  sts_o,
   output logic        host_req_o,
   input  logic        host_ack_i,
   output logic [39:0] host_cmd_o,
   output logic [15:0] host_set_o,
   input  logic        host_sreq_i,
   output logic        host_sack_o,
   input  logic [7:0]  host_sts_i,
   input  logic [39:0] host_rsp_i,
   output logic        host_go_idle_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CMPL, S_DRAIN, S_TOUT} state_t;

   state_t      state, state_nxt;
   logic        rr_last, rr_last_nxt;   // 1 = port B was granted last
   logic        gnt_b, gnt_b_nxt;
   logic        pick_b;
   logic        req_nxt, sack_nxt, a_done_nxt, b_done_nxt;
   logic [39:0] cmd_nxt, rsp_nxt;
   logic [15:0] set_nxt;
   logic [7:0]  sts_nxt;

`ifdef SD_CMD_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic            to_ph, to_ph_nxt;
   logic            go_idle_q, go_idle_nxt;
   assign host_go_idle_o = go_idle_q;
`else
   assign host_go_idle_o = 1'b0;
`endif

   assign busy_o = (state != S_IDLE);

   always_comb begin
      state_nxt   = state;
      rr_last_nxt = rr_last;
      gnt_b_nxt   = gnt_b;
      pick_b      = 1'b0;
      req_nxt     = host_req_o;
      sack_nxt    = host_sack_o;
      cmd_nxt     = host_cmd_o;
      set_nxt     = host_set_o;
      rsp_nxt     = rsp_o;
      sts_nxt     = sts_o;
      a_done_nxt  = 1'b0;
      b_done_nxt  = 1'b0;
`ifdef SD_CMD_TIMEOUT_EN
      to_cnt_nxt  = to_cnt;
      to_ph_nxt   = to_ph;
      go_idle_nxt = go_idle_q;
`endif
      case (state)
         S_IDLE: begin
            if ((a_req_i || b_req_i) && host_ack_i) begin
               // On a tie the port that was not served last wins
               pick_b      = b_req_i && (!a_req_i || !rr_last);
               gnt_b_nxt   = pick_b;
               rr_last_nxt = pick_b;
               cmd_nxt     = pick_b ? b_cmd_i : a_cmd_i;
               set_nxt     = pick_b ? b_set_i : a_set_i;
               req_nxt     = 1'b1;
               state_nxt   = S_ISSUE;
`ifdef SD_CMD_TIMEOUT_EN
               to_cnt_nxt  = '0;
`endif
            end
         end
         S_ISSUE: begin
            if (!host_ack_i) begin
               req_nxt   = 1'b0;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            sack_nxt = host_sreq_i;
            if (host_sreq_i) begin
               if (host_sts_i[6]) begin
                  rsp_nxt   = host_rsp_i;
                  sts_nxt   = host_sts_i;
                  state_nxt = S_CMPL;
               end else begin
                  sts_nxt[3:0] = host_sts_i[3:0];
               end
            end
         end
         S_CMPL: begin
            if (host_ack_i) begin
               sack_nxt   = 1'b0;
               a_done_nxt = !gnt_b;
               b_done_nxt = gnt_b;
               state_nxt  = S_DRAIN;
            end
         end
         S_DRAIN: state_nxt = S_IDLE;
         S_TOUT: begin
`ifdef SD_CMD_TIMEOUT_EN
            // go-idle is held for two cycles before the requester is released
            if (!to_ph) begin
               to_ph_nxt = 1'b1;
            end else begin
               go_idle_nxt = 1'b0;
               a_done_nxt  = !gnt_b;
               b_done_nxt  = gnt_b;
               state_nxt   = S_DRAIN;
            end
`else
            state_nxt = S_IDLE;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
`ifdef SD_CMD_TIMEOUT_EN
      if (state == S_ISSUE || state == S_WAIT || state == S_CMPL) begin
         to_cnt_nxt = to_cnt + 1'b1;
         if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            state_nxt   = S_TOUT;
            to_ph_nxt   = 1'b0;
            go_idle_nxt = 1'b1;
            req_nxt     = 1'b0;
            sack_nxt    = 1'b0;
            sts_nxt     = 8'h80;
            rsp_nxt     = '0;
         end
      end
`endif
   end

   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state       <= S_IDLE;
         rr_last     <= 1'b1;
         gnt_b       <= 1'b0;
         host_req_o  <= 1'b0;
         host_sack_o <= 1'b0;
         host_cmd_o  <= '0;
         host_set_o  <= '0;
         rsp_o       <= '0;
         sts_o       <= '0;
         a_done_o    <= 1'b0;
         b_done_o    <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_last     <= rr_last_nxt;
         gnt_b       <= gnt_b_nxt;
         host_req_o  <= req_nxt;
         host_sack_o <= sack_nxt;
         host_cmd_o  <= cmd_nxt;
         host_set_o  <= set_nxt;
         rsp_o       <= rsp_nxt;
         sts_o       <= sts_nxt;
         a_done_o    <= a_done_nxt;
         b_done_o    <= b_done_nxt;
      end
   end

`ifdef SD_CMD_TIMEOUT_EN
   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         to_cnt    <= '0;
         to_ph     <= 1'b0;
         go_idle_q <= 1'b0;
      end else begin
         to_cnt    <= to_cnt_nxt;
         to_ph     <= to_ph_nxt;
         go_idle_q <= go_idle_nxt;
      end
   end
`endif

endmodule
